manual_clock_ctrl: RTL and testbench
====================================

# manual_clock_ctrl

Sequencer for the manual clock path: it takes the debounced push-button level from the gate-level SR latch (Q/Qn pair) and turns it into single-cycle clock-enable ticks for the rest of the design. It supports three modes: single step, free run at a programmable period, and a fixed-length burst. It sits between the SR latch and every module that advances on the manual clock enable, and it flags latch contact faults.

## Interface
- DIV_WIDTH, 16, width of run/burst period divisor
- BURST_WIDTH, 8, width of burst length
- SYNC_STAGES, 2, synchronizer depth for latch outputs (min 2)

- Clk  input  1  system clock, all logic on rising edge
- Reset  input  1  synchronous, active-high
- LatchQ  input  1  SR latch Q (asynchronous; 1 = button pressed)
- LatchQn  input  1  SR latch Qn (asynchronous; 0 = button pressed)
- Mode  input  2  00 step, 01 run, 10 burst, 11 treated as step
- Divisor  input  DIV_WIDTH  tick period in Clk cycles for run/burst; 0 treated as 1
- BurstLen  input  BURST_WIDTH  ticks per burst; 0 treated as step
- Tick  output  1  one-cycle clock enable (registered)
- Busy  output  1  high whenever state != IDLE (registered)
- TickCount  output  16  count of Ticks issued, wraps 0xFFFF -> 0x0000
- Fault  output  1  sticky latch fault flag

## Operation
- Synchronizers: LatchQ and LatchQn each pass through SYNC_STAGES flops; sQ/sQn are the final stage values. Reset loads sQ=0 and sQn=1 in every stage (the released state).
- Valid level: pressed when sQ=1 and sQn=0; released when sQ=0 and sQn=1. Any other combination is invalid.
- Press event: one-cycle pulse when the level goes from not-pressed to pressed in consecutive cycles. Invalid levels never generate a press event.
- Fault: set when sQ==sQn for 4 consecutive cycles. It stays set until Reset and does not block operation.
- States: IDLE, HOLD, RUN, BURST.
- IDLE, on press event:
  - Mode 00/11: Tick=1 next cycle, go HOLD.
  - Mode 01: load divider with max(Divisor,1)-1, go RUN.
  - Mode 10 with BurstLen==0: behaves as step.
  - Mode 10 otherwise: load divider, load remaining=BurstLen, go BURST.
- HOLD: go IDLE when the synced level is released. Invalid levels keep HOLD.
- RUN:
  - Divider decrements each cycle. At 0: Tick=1, reload from current Divisor.
  - Press event: go HOLD with no Tick that cycle; the press takes priority over divider expiry.
  - Mode != 01: go IDLE with no Tick.
- BURST:
  - Same divider behaviour as RUN. Each Tick decrements remaining.
  - On the Tick that makes remaining 0: go HOLD.
  - Press event: abort to HOLD with no Tick.
  - Mode changes are ignored until the burst finishes.
- TickCount increments in the same cycle Tick is high.
- Reset mid-operation: next state is IDLE. Tick=0, Busy=0, TickCount=0, Fault=0, divider=0, remaining=0. Synchronizers are released.

## Timing
- Step latency: Tick is high on the cycle after the press event. Press event occurs SYNC_STAGES+1 rising edges after LatchQ/LatchQn settle pressed, so Tick is seen SYNC_STAGES+2 edges after input change.
- Tick is always exactly one cycle wide. Step mode yields exactly one Tick per press, however long the press is held.
- Run/burst: the first Tick comes max(Divisor,1) cycles after the press event. After that, Ticks come every max(Divisor,1) cycles; Divisor is resampled at each reload.
- Divisor=1 (or 0): Tick every cycle in RUN/BURST.
- Busy rises the cycle after the press event and falls the cycle after HOLD sees release.
- TickCount and Fault are registered and update one cycle after their cause.

## Test plan
- Reset: hold Reset 3 cycles with LatchQ=1, LatchQn=0 -> Tick=0, Busy=0, TickCount=0, Fault=0. First press event occurs only after SYNC_STAGES+1 cycles post-reset.
- Step: Mode=00, press held 50 cycles, then release, repeated 3 times -> exactly 3 single-cycle Ticks, each SYNC_STAGES+2 edges after press. TickCount=3; Busy drops after each release.
- Run: Mode=01, Divisor=4, press/release, then 20 cycles -> Ticks every 4 cycles, first at 4 cycles after press event. A second press stops ticks and goes HOLD; Divisor=0 gives a Tick every cycle.
- Burst: Mode=10, Divisor=3, BurstLen=5 -> exactly 5 Ticks spaced 3 cycles, then IDLE after release. A press during the 3rd interval aborts with TickCount=2.
- Fault: LatchQ=LatchQn=1 for 3 cycles -> Fault stays 0. Holding them equal for 6 cycles -> Fault=1 and stays set, no press events occur, and the flag clears only on Reset.
- Wrap: preload via 65536 run ticks (Divisor=1) -> TickCount wraps from 0xFFFF to 0x0000.

Source files
------------

// File: rtl/manual_clock_ctrl.sv
// Manual clock sequencer: turns the synchronised SR-latch button level into
// single-cycle clock-enable ticks (step, free run, burst) and flags latch faults.
module manual_clock_ctrl #(
    parameter int DIV_WIDTH   = 16,
    parameter int BURST_WIDTH = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   latch_q,
    input  logic                   latch_qn,
    input  logic [1:0]             mode,
    input  logic [DIV_WIDTH-1:0]   divisor,
    input  logic [BURST_WIDTH-1:0] burst_len,
    output logic                   tick,
    output logic                   busy,
    output logic [15:0]            tick_count,
    output logic                   fault
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    localparam logic [DIV_WIDTH-1:0]   DIV_ZERO = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0]   DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BURST_WIDTH-1:0] REM_ZERO = {BURST_WIDTH{1'b0}};
    localparam logic [BURST_WIDTH-1:0] REM_ONE  = {{(BURST_WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] q_sync_r;
    logic [SYNC_STAGES-1:0] qn_sync_r;
    logic                   sq_s;
    logic                   sqn_s;
    logic                   pressed_s;
    logic                   released_s;
    logic                   equal_s;
    logic                   prev_pressed_r;
    logic                   press_evt_r;
    logic [1:0]             eq_cnt_r;
    logic                   fault_r;
    state_t                 state_r;
    logic                   tick_r;
    logic                   busy_r;
    logic [15:0]            tick_count_r;
    logic [DIV_WIDTH-1:0]   div_r;
    logic [BURST_WIDTH-1:0] rem_r;

    // A divisor of zero behaves like one: reload value is max(d,1)-1.
    function automatic logic [DIV_WIDTH-1:0] div_reload(input logic [DIV_WIDTH-1:0] d);
        return (d == DIV_ZERO) ? DIV_ZERO : (d - DIV_ONE);
    endfunction

    // Synchronise both latch rails; reset parks them in the released state.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_sync_r  <= {SYNC_STAGES{1'b0}};
            qn_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            q_sync_r  <= {q_sync_r[SYNC_STAGES-2:0], latch_q};
            qn_sync_r <= {qn_sync_r[SYNC_STAGES-2:0], latch_qn};
        end
    end

    assign sq_s       = q_sync_r[SYNC_STAGES-1];
    assign sqn_s      = qn_sync_r[SYNC_STAGES-1];
    assign pressed_s  = sq_s & ~sqn_s;
    assign released_s = ~sq_s & sqn_s;
    assign equal_s    = (sq_s == sqn_s);

    // Registered press event: not-pressed to pressed across consecutive cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pressed_r <= 1'b0;
            press_evt_r    <= 1'b0;
        end else begin
            prev_pressed_r <= pressed_s;
            press_evt_r    <= pressed_s & ~prev_pressed_r;
        end
    end

    // Sticky fault once both rails agree for four consecutive cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            eq_cnt_r <= 2'd0;
            fault_r  <= 1'b0;
        end else if (equal_s) begin
            if (eq_cnt_r == 2'd3) begin
                fault_r <= 1'b1;
            end else begin
                eq_cnt_r <= eq_cnt_r + 2'd1;
            end
        end else begin
            eq_cnt_r <= 2'd0;
        end
    end

    // Sequencer FSM; busy tracks leaving and re-entering IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            tick_r       <= 1'b0;
            busy_r       <= 1'b0;
            tick_count_r <= 16'd0;
            div_r        <= DIV_ZERO;
            rem_r        <= REM_ZERO;
        end else begin
            tick_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (press_evt_r) begin
                        busy_r <= 1'b1;
                        if (mode == 2'b01) begin
                            div_r   <= div_reload(divisor);
                            state_r <= ST_RUN;
                        end else if ((mode == 2'b10) && (burst_len != REM_ZERO)) begin
                            div_r   <= div_reload(divisor);
                            rem_r   <= burst_len;
                            state_r <= ST_BURST;
                        end else begin
                            tick_r       <= 1'b1;
                            tick_count_r <= tick_count_r + 16'd1;
                            state_r      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (released_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // A fresh press wins over a divider expiry in the same cycle.
                    if (press_evt_r) begin
                        state_r <= ST_HOLD;
                    end else if (mode != 2'b01) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (div_r == DIV_ZERO) begin
                        tick_r       <= 1'b1;
                        tick_count_r <= tick_count_r + 16'd1;
                        div_r        <= div_reload(divisor);
                    end else begin
                        div_r <= div_r - DIV_ONE;
                    end
                end
                ST_BURST: begin
                    if (press_evt_r) begin
                        state_r <= ST_HOLD;
                    end else if (div_r == DIV_ZERO) begin
                        tick_r       <= 1'b1;
                        tick_count_r <= tick_count_r + 16'd1;
                        div_r        <= div_reload(divisor);
                        rem_r        <= rem_r - REM_ONE;
                        if (rem_r == REM_ONE) begin
                            state_r <= ST_HOLD;
                        end
                    end else begin
                        div_r <= div_r - DIV_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign tick       = tick_r;
    assign busy       = busy_r;
    assign tick_count = tick_count_r;
    assign fault      = fault_r;

endmodule

// File: tb/tb_manual_clock_ctrl.sv
// Self-checking bench for manual_clock_ctrl: a cycle-level behavioural model
// built on input history and tick deadlines, plus hand-computed checkpoints.
module tb_manual_clock_ctrl;

    localparam int S = 2;
    localparam int HD = S + 4;
    localparam int P_IDLE  = 0;
    localparam int P_HOLD  = 1;
    localparam int P_RUN   = 2;
    localparam int P_BURST = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        latch_q;
    logic        latch_qn;
    logic [1:0]  mode;
    logic [15:0] divisor;
    logic [7:0]  burst_len;
    logic        tick;
    logic        busy;
    logic [15:0] tick_count;
    logic        fault;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: input history seen at each edge (index 0 = latest edge)
    logic [1:0]  hist [0:HD-1];
    int          phase = P_IDLE;
    int          cyc_n = 0;
    int          next_tick = 0;
    int          left = 0;
    logic        m_tick = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_fault = 1'b0;
    logic [15:0] m_count = 16'd0;

    always #5 clk = ~clk;

    manual_clock_ctrl #(.DIV_WIDTH(16), .BURST_WIDTH(8), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .latch_q(latch_q), .latch_qn(latch_qn),
        .mode(mode), .divisor(divisor), .burst_len(burst_len),
        .tick(tick), .busy(busy), .tick_count(tick_count), .fault(fault)
    );

    function automatic int dmax(input logic [15:0] d);
        return (d == 16'd0) ? 1 : int'(d);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic pe;
        logic all_eq;
        cyc_n++;
        if (reset) begin
            for (int k = 0; k < HD; k++) hist[k] = 2'b01;
            phase   = P_IDLE;
            m_tick  = 1'b0;
            m_busy  = 1'b0;
            m_count = 16'd0;
            m_fault = 1'b0;
        end else begin
            for (int k = HD - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = {latch_q, latch_qn};
            pe = (hist[S+1] == 2'b10) && (hist[S+2] != 2'b10);
            all_eq = 1'b1;
            for (int k = S; k <= S + 3; k++)
                if (hist[k][1] != hist[k][0]) all_eq = 1'b0;
            if (all_eq) m_fault = 1'b1;
            m_tick = 1'b0;
            case (phase)
                P_IDLE: if (pe) begin
                    if (mode == 2'b01) begin
                        phase = P_RUN;
                        next_tick = cyc_n + dmax(divisor);
                    end else if (mode == 2'b10 && burst_len != 8'd0) begin
                        phase = P_BURST;
                        left = int'(burst_len);
                        next_tick = cyc_n + dmax(divisor);
                    end else begin
                        m_tick = 1'b1;
                        phase = P_HOLD;
                    end
                end
                P_HOLD: if (hist[S] == 2'b01) phase = P_IDLE;
                P_RUN: begin
                    if (pe) phase = P_HOLD;
                    else if (mode != 2'b01) phase = P_IDLE;
                    else if (cyc_n == next_tick) begin
                        m_tick = 1'b1;
                        next_tick = cyc_n + dmax(divisor);
                    end
                end
                default: begin
                    if (pe) phase = P_HOLD;
                    else if (cyc_n == next_tick) begin
                        m_tick = 1'b1;
                        left--;
                        next_tick = cyc_n + dmax(divisor);
                        if (left == 0) phase = P_HOLD;
                    end
                end
            endcase
            if (m_tick) m_count = m_count + 16'd1;
            m_busy = (phase != P_IDLE);
        end
    endtask

    // one clock: model advances on the edge, DUT is compared 1 ns later
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("tick", {31'd0, tick}, {31'd0, m_tick});
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("tick_count", {16'd0, tick_count}, {16'd0, m_count});
        check("fault", {31'd0, fault}, {31'd0, m_fault});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic press();
        latch_q = 1'b1; latch_qn = 1'b0;
    endtask

    task automatic release_btn();
        latch_q = 1'b0; latch_qn = 1'b1;
    endtask

    // runs n cycles, releasing after cycle rel_at; reports first tick index and tick total
    task automatic run_obs(input int n, input int rel_at, output int first, output int nt);
        first = -1;
        nt = 0;
        for (int i = 1; i <= n; i++) begin
            cyc();
            if (tick === 1'b1) begin
                nt++;
                if (first < 0) first = i;
            end
            if (i == rel_at) release_btn();
        end
    endtask

    task automatic wait_tick(input int limit, output int k);
        k = -1;
        for (int i = 1; i <= limit; i++) begin
            cyc();
            if (tick === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int k;
        int f;
        int nt;
        int tot;
        reset = 1'b1; mode = 2'b00; divisor = 16'd4; burst_len = 8'd5;
        press();
        run(3);
        check("reset_tick", {31'd0, tick}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_count", {16'd0, tick_count}, 32'd0);
        check("reset_fault", {31'd0, fault}, 32'd0);
        reset = 1'b0;

        // step mode: three held presses, one tick each
        for (int p = 0; p < 3; p++) begin
            if (p > 0) press();
            wait_tick(10, k);
            check("step_latency", k, S + 2);
            cyc();
            check("step_width", {31'd0, tick}, 32'd0);
            run(45);
            release_btn();
            run(10);
            check("step_busy_drop", {31'd0, busy}, 32'd0);
        end
        check("step_count", {16'd0, tick_count}, 32'd3);

        // run mode, divisor 4
        mode = 2'b01; divisor = 16'd4;
        press();
        run_obs(26, 6, f, nt);
        check("run_first", f, 32'd8);
        check("run_ticks", nt, 32'd5);
        press();
        run_obs(20, 6, f, nt);
        check("run_stop_ticks", nt, 32'd1);
        check("run_stop_idle", {31'd0, busy}, 32'd0);
        divisor = 16'd0;
        press();
        run_obs(10, 6, f, nt);
        check("run_div0_first", f, 32'd5);
        check("run_div0_ticks", nt, 32'd6);
        mode = 2'b00;
        run_obs(5, 0, f, nt);
        check("run_mode_exit", nt, 32'd0);
        check("run_mode_idle", {31'd0, busy}, 32'd0);

        // burst of 5 spaced 3, mode change ignored mid-burst
        mode = 2'b10; divisor = 16'd3; burst_len = 8'd5;
        press();
        run_obs(6, 6, f, nt);
        mode = 2'b00;
        run_obs(19, 0, f, nt);
        check("burst_first", f, 32'd1);
        check("burst_ticks", nt, 32'd5);
        check("burst_idle", {31'd0, busy}, 32'd0);

        // burst aborted by a press in the third interval
        mode = 2'b10;
        press();
        run_obs(6, 6, f, nt);
        tot = nt;
        run_obs(2, 0, f, nt);
        tot += nt;
        press();
        run_obs(6, 6, f, nt);
        tot += nt;
        run_obs(10, 0, f, nt);
        tot += nt;
        check("abort_ticks", tot, 32'd2);
        check("abort_count", {16'd0, tick_count}, 32'd22);
        check("abort_idle", {31'd0, busy}, 32'd0);

        // latch faults
        mode = 2'b00;
        latch_q = 1'b1; latch_qn = 1'b1;
        run(3);
        release_btn();
        run(10);
        check("fault_short", {31'd0, fault}, 32'd0);
        latch_q = 1'b1; latch_qn = 1'b1;
        run(6);
        release_btn();
        run(10);
        check("fault_set", {31'd0, fault}, 32'd1);
        check("fault_no_press", {16'd0, tick_count}, 32'd22);

        // reset in the middle of a run
        mode = 2'b01; divisor = 16'd2;
        press();
        run(6);
        release_btn();
        run(6);
        reset = 1'b1;
        run(2);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_count", {16'd0, tick_count}, 32'd0);
        check("midreset_fault", {31'd0, fault}, 32'd0);
        reset = 1'b0;
        run(4);
        check("midreset_tick", {31'd0, tick}, 32'd0);

        // TickCount wrap at divisor 1
        divisor = 16'd1;
        press();
        run(6);
        release_btn();
        run(65533);
        check("wrap_ffff", {16'd0, tick_count}, 32'h0000FFFF);
        run(1);
        check("wrap_zero", {16'd0, tick_count}, 32'd0);
        mode = 2'b00;
        run(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
